// File: rtl/word_serializer_pkg.sv
// Shared types and sizing helpers for the word serializer.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_serializer_bit_down_counter.sv
// Loadable down-counter with enable, async clear and a count==1 flag.
module bit_down_counter
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          is_one
);

    logic [CW-1:0] count;

    // Saturates at zero so a stray enable can never wrap the count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign is_one = (count == CW'(1));

endmodule

// File: rtl/word_serializer.sv
// Parallel-in/serial-out loader, MSB first, with valid/ready input and stall.
// Optional even-parity trailer bit enabled by WORD_SERIALIZER_PARITY_EN.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic             cnt_load, cnt_en, cnt_one, done_nx;

    bit_down_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (FULL),
        .en       (cnt_en),
        .is_one   (cnt_one)
    );

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    cnt_load = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    cnt_en = 1'b1;
                    if (cnt_one) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = IDLE;
                        done_nx  = 1'b1;
`endif
                    end
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                if (ser_en) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            shreg      <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= done_nx;
            if (cnt_load) begin
                shreg <= load_data;
            end else if (cnt_en) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef WORD_SERIALIZER_PARITY_EN
    logic parity;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            parity <= 1'b0;
        end else if (cnt_load) begin
            parity <= ^load_data;
        end
    end
`endif

    // Outputs decode registered state only; no input reaches an output.
    always_comb begin
        ser_out = 1'b0;
        case (state)
            SHIFT:   ser_out = shreg[WIDTH-1];
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY:  ser_out = parity;
`endif
            default: ser_out = 1'b0;
        endcase
    end

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign ser_valid  = (state != IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Directed table-driven bench for word_serializer (WIDTH=5).
module tb_word_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         ser_en;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         frame_done;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic         lv;
        logic [W-1:0] d;
        logic         en;
        logic [4:0]   exp; // {ser_out, ser_valid, busy, frame_done, load_ready}
    } vec_t;

    vec_t tbl[$];

    word_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_en     (ser_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {ser_out, ser_valid, busy, frame_done, load_ready};
    endfunction

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got {out,vld,busy,done,rdy}=%b expected %b", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void push(input logic lv, input logic [W-1:0] d, input logic en,
                                 input logic o, input logic v, input logic b,
                                 input logic fd, input logic lr);
        vec_t e;
        e.lv  = lv;
        e.d   = d;
        e.en  = en;
        e.exp = {o, v, b, fd, lr};
        tbl.push_back(e);
    endfunction

    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            load_valid = tbl[i].lv;
            load_data  = tbl[i].d;
            ser_en     = tbl[i].en;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", nm, i), outs(), tbl[i].exp);
        end
        tbl.delete();
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    initial begin
        clr        = 1'b1;
        load_data  = '0;
        load_valid = 1'b0;
        ser_en     = 1'b0;
        #12;
        chk("reset_state", outs(), 5'b00001);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Basic frame 10110 with ser_en held high
        //   lv  data      en  out vld busy fd rdy
        push(1, 5'b10110, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
`ifdef WORD_SERIALIZER_PARITY_EN
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
`endif
        push(0, 5'b00000, 1,  0,  0,  0,  1,  1);
        push(0, 5'b00000, 1,  0,  0,  0,  0,  1);
        run_table("basic");

        // Stall two cycles while the third bit is shown
        push(1, 5'b10110, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 0,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 0,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
`ifdef WORD_SERIALIZER_PARITY_EN
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
`endif
        push(0, 5'b00000, 1,  0,  0,  0,  1,  1);
        push(0, 5'b00000, 1,  0,  0,  0,  0,  1);
        run_table("stall");

        // Load while busy: second word waits for the IDLE cycle
        push(1, 5'b11111, 1,  1,  1,  1,  0,  0);
        push(1, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(1, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(1, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(1, 5'b00000, 1,  1,  1,  1,  0,  0);
`ifdef WORD_SERIALIZER_PARITY_EN
        push(1, 5'b00000, 1,  1,  1,  1,  0,  0);
`endif
        push(1, 5'b00000, 1,  0,  0,  0,  1,  1);
        push(1, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
`ifdef WORD_SERIALIZER_PARITY_EN
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
`endif
        push(0, 5'b00000, 1,  0,  0,  0,  1,  1);
        push(0, 5'b00000, 1,  0,  0,  0,  0,  1);
        run_table("busy_load");

`ifdef WORD_SERIALIZER_PARITY_EN
        // Parity of 10100 is 0
        push(1, 5'b10100, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  0,  0,  1,  1);
        push(0, 5'b00000, 1,  0,  0,  0,  0,  1);
        run_table("parity0");
`endif

        // Asynchronous reset mid-frame after two bits of 10101
        push(1, 5'b10101, 1,  1,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  0,  1,  1,  0,  0);
        push(0, 5'b00000, 1,  1,  1,  1,  0,  0);
        run_table("pre_abort");
        #3;
        clr = 1'b1;
        #1;
        chk("abort_immediate", outs(), 5'b00001);
        @(posedge clk);
        #1;
        chk("abort_held", outs(), 5'b00001);
        clr    = 1'b0;
        ser_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_no_done[%0d]", i), outs(), 5'b00001);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
